cache_req_arbiter: RTL and testbench
====================================

// Module: cache_req_arbiter
// PURPOSE
//  Shares one cache slave port between NREQ requesters (e.g. I-fetch, D-access,
//  DMA) and injects evict requests ahead of them. Round-robin arbitration,
//  one outstanding cache transaction at a time, latched request payload.
//  Watchdog aborts a hung transaction. Sits directly in front of the cache.
// PARAMETERS
//  NREQ      3    number of requesters (2..8)
//  ADDRW     32   address width
//  WORDW     32   data word width
//  TIMEOUT   255  max cycles waiting for c_done before abort (1..65535)
// PORTS
//  clock        in   1            system clock
//  reset        in   1            synchronous, active-high reset
//  req          in   NREQ         per-requester request, held until done
//  req_we       in   NREQ         1=write, 0=read
//  req_addr     in   NREQ*ADDRW   per-requester address
//  req_wdata    in   NREQ*WORDW   per-requester write data
//  req_done     out  NREQ         one-cycle completion pulse, one-hot
//  req_err      out  1            qualifies req_done: transaction timed out
//  rdata        out  WORDW        read data, valid with req_done
//  evict_req    in   1            evict request, held until evict_ack
//  evict_addr   in   ADDRW        evict address
//  evict_ack    out  1            one-cycle pulse, evict finished
//  c_request    out  1            cache request
//  c_evict      out  1            cache evict
//  c_we         out  1            cache write enable
//  c_addr       out  ADDRW        cache address
//  c_wdata      out  WORDW        cache write data
//  c_rdata      in   WORDW        cache read data
//  c_done       in   1            cache completion, one cycle
// BEHAVIOUR
//  States: IDLE, BUSY, EVICT. All outputs registered.
//  Reset (sync, priority over everything, aborts any state): state=IDLE,
//   rr_ptr=0, wd_cnt=0, all outputs 0 incl. rdata/c_addr/c_wdata.
//  IDLE: evict_req=1 -> latch evict_addr, c_evict=1, ->EVICT (evict beats reqs).
//   Else any req -> winner = first set bit at/after rr_ptr, wrapping NREQ-1->0;
//   latch addr/we/wdata, c_request=1, ->BUSY. Else stay.
//  Latency: req sampled in cycle t -> c_request high in t+1.
//  BUSY: c_request held, payload stable. c_done=1 -> c_request=0,
//   rdata<=c_rdata, req_done[winner]=1 next cycle, rr_ptr=(winner+1)%NREQ,
//   ->IDLE. Requester dropping req in BUSY is ignored; transaction completes.
//  EVICT: c_evict held. c_done -> c_evict=0, evict_ack=1 next cycle, ->IDLE.
//   rr_ptr unchanged.
//  Watchdog: wd_cnt clears on BUSY/EVICT entry, +1 per cycle without c_done.
//   At wd_cnt==TIMEOUT: drop c_request/c_evict, ->IDLE. From BUSY: pulse
//   req_done[winner] with req_err=1, rdata unchanged, rr_ptr advances. From
//   EVICT: pulse evict_ack. c_done in the same cycle as expiry wins (normal).
//  IDLE lasts >=1 cycle between transactions: back-to-back max 1 txn per 3 cyc
//   (1-cycle cache); requester whose req_done just pulsed must deassert req
//   that cycle or it is re-arbitrated at lowest priority.
//  c_done outside BUSY/EVICT ignored. evict_req rising in BUSY waits for IDLE.
//  Width rules: rr_ptr $clog2(NREQ) bits, wrap explicitly (NREQ need not be
//   pow2); wd_cnt $clog2(TIMEOUT+1) bits, no wrap.
// TESTING
//  1. req=3'b001,addr0=0x100,we=0; c_done 2 cyc after c_request, c_rdata=
//     0xDEADBEEF -> c_addr=0x100, req_done=001, rdata=0xDEADBEEF, rr_ptr=1.
//  2. req=3'b111 held, 1-cycle cache -> grant order 0,1,2,0; each req_done
//     one-hot; never two c_request without IDLE gap.
//  3. evict_req=1 and req=3'b010 same cycle in IDLE -> c_evict first,
//     evict_ack, then c_request with addr1; rr_ptr unaffected by evict.
//  4. TIMEOUT=4, no c_done -> c_request high exactly 5 cycles, req_done[w]
//     with req_err=1, next arbitration skips w.
//  5. reset in BUSY mid-write -> next cycle all outputs 0, state IDLE, no
//     req_done; subsequent req=3'b100 granted from rr_ptr=0 scan -> req 2.
//  6. req=3'b010 dropped in BUSY; c_done -> req_done=010 still pulses.

Source files
------------

// File: rtl/cache_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// cache_req_arbiter_if
//   Bundles every signal between the cache request arbiter, its requesters,
//   the evict source and the cache slave port.
//
//   Handshake semantics (requester side and cache side):
//     - req[i] acts as a valid. Once raised, it stays high with a stable
//       payload (req_we/req_addr/req_wdata) until req_done[i] pulses.
//       req_done is a one-cycle, one-hot completion. req_err qualifies it as
//       a watchdog abort. rdata is valid in the req_done cycle.
//     - evict_req/evict_addr follow the same rule and complete on evict_ack.
//     - c_request or c_evict acts as a valid towards the cache, with a stable
//       c_we/c_addr/c_wdata, until the cycle after c_done is sampled.
//       c_done is a one-cycle ready/completion from the cache.
//
//   Modports:
//     master : the arbiter. It drives completions and the cache request.
//     slave  : the environment, i.e. the requesters plus the cache.
// ---------------------------------------------------------------------------
interface cache_req_arbiter_if #(
  parameter int NREQ  = 3,
  parameter int ADDRW = 32,
  parameter int WORDW = 32
);
  // requester side
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       req_we;
  logic [NREQ*ADDRW-1:0] req_addr;
  logic [NREQ*WORDW-1:0] req_wdata;
  logic [NREQ-1:0]       req_done;
  logic                  req_err;
  logic [WORDW-1:0]      rdata;
  // evict source
  logic                  evict_req;
  logic [ADDRW-1:0]      evict_addr;
  logic                  evict_ack;
  // cache slave port
  logic                  c_request;
  logic                  c_evict;
  logic                  c_we;
  logic [ADDRW-1:0]      c_addr;
  logic [WORDW-1:0]      c_wdata;
  logic [WORDW-1:0]      c_rdata;
  logic                  c_done;

  modport master (
    input  req, req_we, req_addr, req_wdata, evict_req, evict_addr,
           c_rdata, c_done,
    output req_done, req_err, rdata, evict_ack,
           c_request, c_evict, c_we, c_addr, c_wdata
  );

  modport slave (
    output req, req_we, req_addr, req_wdata, evict_req, evict_addr,
           c_rdata, c_done,
    input  req_done, req_err, rdata, evict_ack,
           c_request, c_evict, c_we, c_addr, c_wdata
  );
endinterface

// File: rtl/cache_req_arbiter.sv
// ---------------------------------------------------------------------------
// cache_req_arbiter
//   Shares one cache slave port between NREQ requesters and gives evict
//   requests priority over them. Requesters are served round-robin. Only one
//   cache transaction is outstanding at a time, and the winning payload is
//   latched for the whole transaction. A watchdog aborts a transaction when
//   the cache does not answer within TIMEOUT cycles.
//
// Ports:
//   clock        system clock
//   reset        synchronous, active-high reset
//   bus          cache_req_arbiter_if.master (requesters, evict, cache port)
//   dbg_state_o  current FSM state (IDLE=0, BUSY=1, EVICT=2)
//   dbg_rr_ptr_o current round-robin pointer
//
// All outputs are registered. Every transaction is followed by at least one
// IDLE cycle before the next one is started.
// ---------------------------------------------------------------------------
module cache_req_arbiter #(
  parameter int NREQ    = 3,
  parameter int ADDRW   = 32,
  parameter int WORDW   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      clock,
  input  logic                      reset,
  cache_req_arbiter_if.master       bus,
  output logic [1:0]                dbg_state_o,
  output logic [$clog2(NREQ)-1:0]   dbg_rr_ptr_o
);

  localparam int PTRW = $clog2(NREQ);
  localparam int WDW  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_EVICT = 2'd2;

  // state and bookkeeping
  logic [1:0]       state_q,     state_d;
  logic [PTRW-1:0]  rr_ptr_q,    rr_ptr_d;
  logic [PTRW-1:0]  win_q,       win_d;
  logic [WDW-1:0]   wd_cnt_q,    wd_cnt_d;
  // registered outputs
  logic             c_request_q, c_request_d;
  logic             c_evict_q,   c_evict_d;
  logic             c_we_q,      c_we_d;
  logic [ADDRW-1:0] c_addr_q,    c_addr_d;
  logic [WORDW-1:0] c_wdata_q,   c_wdata_d;
  logic [WORDW-1:0] rdata_q,     rdata_d;
  logic [NREQ-1:0]  req_done_q,  req_done_d;
  logic             req_err_q,   req_err_d;
  logic             evict_ack_q, evict_ack_d;

  // Per-requester payload split out of the packed buses so the winner can
  // be selected with a plain array index.
  logic [ADDRW-1:0] addr_a  [NREQ];
  logic [WORDW-1:0] wdata_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_a[g]  = bus.req_addr[g*ADDRW +: ADDRW];
    assign wdata_a[g] = bus.req_wdata[g*WORDW +: WORDW];
  end

  // Round-robin scan. The first set request at or after rr_ptr wins. The
  // wrap is done by subtraction because NREQ need not be a power of two.
  logic            found;
  logic [PTRW-1:0] win_idx;
  logic [PTRW-1:0] cand;
  int              scan_idx;

  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    cand     = '0;
    scan_idx = 0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = int'(rr_ptr_q) + i;
      if (scan_idx >= NREQ) begin
        scan_idx = scan_idx - NREQ;
      end
      cand = PTRW'(scan_idx);
      if (!found && bus.req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Pointer value after the current winner, wrapped explicitly.
  logic [PTRW-1:0] adv_ptr;
  assign adv_ptr = (win_q == PTRW'(NREQ - 1)) ? '0 : win_q + PTRW'(1);

  logic wd_expired;
  assign wd_expired = (wd_cnt_q == WDW'(TIMEOUT));

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_d       = win_q;
    wd_cnt_d    = wd_cnt_q;
    c_request_d = c_request_q;
    c_evict_d   = c_evict_q;
    c_we_d      = c_we_q;
    c_addr_d    = c_addr_q;
    c_wdata_d   = c_wdata_q;
    rdata_d     = rdata_q;
    req_done_d  = '0;
    req_err_d   = 1'b0;
    evict_ack_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.evict_req) begin
          c_addr_d  = bus.evict_addr;
          c_we_d    = 1'b0;
          c_evict_d = 1'b1;
          wd_cnt_d  = '0;
          state_d   = ST_EVICT;
        end else if (found) begin
          win_d       = win_idx;
          c_addr_d    = addr_a[win_idx];
          c_wdata_d   = wdata_a[win_idx];
          c_we_d      = bus.req_we[win_idx];
          c_request_d = 1'b1;
          wd_cnt_d    = '0;
          state_d     = ST_BUSY;
        end
      end

      ST_BUSY: begin
        // c_done beats the watchdog when both land in the same cycle.
        if (bus.c_done) begin
          c_request_d       = 1'b0;
          rdata_d           = bus.c_rdata;
          req_done_d[win_q] = 1'b1;
          rr_ptr_d          = adv_ptr;
          state_d           = ST_IDLE;
        end else if (wd_expired) begin
          c_request_d       = 1'b0;
          req_done_d[win_q] = 1'b1;
          req_err_d         = 1'b1;
          rr_ptr_d          = adv_ptr;
          state_d           = ST_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + WDW'(1);
        end
      end

      ST_EVICT: begin
        if (bus.c_done || wd_expired) begin
          c_evict_d   = 1'b0;
          evict_ack_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + WDW'(1);
        end
      end

      default: begin
        state_d     = ST_IDLE;
        c_request_d = 1'b0;
        c_evict_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      win_q       <= '0;
      wd_cnt_q    <= '0;
      c_request_q <= 1'b0;
      c_evict_q   <= 1'b0;
      c_we_q      <= 1'b0;
      c_addr_q    <= '0;
      c_wdata_q   <= '0;
      rdata_q     <= '0;
      req_done_q  <= '0;
      req_err_q   <= 1'b0;
      evict_ack_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_q       <= win_d;
      wd_cnt_q    <= wd_cnt_d;
      c_request_q <= c_request_d;
      c_evict_q   <= c_evict_d;
      c_we_q      <= c_we_d;
      c_addr_q    <= c_addr_d;
      c_wdata_q   <= c_wdata_d;
      rdata_q     <= rdata_d;
      req_done_q  <= req_done_d;
      req_err_q   <= req_err_d;
      evict_ack_q <= evict_ack_d;
    end
  end

  assign bus.c_request = c_request_q;
  assign bus.c_evict   = c_evict_q;
  assign bus.c_we      = c_we_q;
  assign bus.c_addr    = c_addr_q;
  assign bus.c_wdata   = c_wdata_q;
  assign bus.rdata     = rdata_q;
  assign bus.req_done  = req_done_q;
  assign bus.req_err   = req_err_q;
  assign bus.evict_ack = evict_ack_q;

  assign dbg_state_o  = state_q;
  assign dbg_rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_req_arbiter
//   Directed scenarios plus a short randomised run for cache_req_arbiter.
//   Completions are tracked through a queue of expected
//   {req_err, req_done, rdata} words.
// ---------------------------------------------------------------------------
module tb_cache_req_arbiter;

  localparam int NREQ    = 3;
  localparam int ADDRW   = 32;
  localparam int WORDW   = 32;
  localparam int TIMEOUT = 4;
  localparam int SBW     = 1 + NREQ + WORDW;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  cache_req_arbiter_if #(.NREQ(NREQ), .ADDRW(ADDRW), .WORDW(WORDW)) bus ();

  logic [1:0] dbg_state;
  logic [1:0] dbg_rr_ptr;

  cache_req_arbiter #(
    .NREQ(NREQ), .ADDRW(ADDRW), .WORDW(WORDW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state),
    .dbg_rr_ptr_o(dbg_rr_ptr)
  );

  // ---------------- scoreboard ----------------
  int               vectors     = 0;
  int               miscompares = 0;
  logic [SBW-1:0]   exp_q[$];
  logic [SBW-1:0]   exp_w;
  logic [SBW-1:0]   obs_w;
  logic [ADDRW-1:0] addr_tbl  [NREQ];
  logic [WORDW-1:0] wdata_tbl [NREQ];
  logic [NREQ-1:0]  we_tbl;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_payload();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i*ADDRW +: ADDRW]  = addr_tbl[i];
      bus.req_wdata[i*WORDW +: WORDW] = wdata_tbl[i];
    end
    bus.req_we = we_tbl;
  endtask

  task automatic idle_inputs();
    bus.req        = '0;
    bus.req_we     = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.evict_req  = 1'b0;
    bus.evict_addr = '0;
    bus.c_rdata    = '0;
    bus.c_done     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Bounded wait for the cache-side request or evict.
  task automatic wait_grant(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.c_request || bus.c_evict) begin
        ok = 1'b1;
        break;
      end
      tick();
      n++;
    end
  endtask

  // Cache answers for one cycle; returns one cycle after c_done is sampled.
  task automatic pulse_done(input logic [WORDW-1:0] d);
    bus.c_rdata = d;
    bus.c_done  = 1'b1;
    tick();
    bus.c_done  = 1'b0;
    bus.c_rdata = $urandom;
  endtask

  function automatic logic [SBW-1:0] sb_word(input logic err,
                                             input int w,
                                             input logic [WORDW-1:0] d);
    logic [NREQ-1:0] oh;
    oh    = '0;
    oh[w] = 1'b1;
    return {err, oh, d};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    bus.req = 3'b111;
    reset   = 1'b1;
    tick();
    tick();
    vectors++;
    if ({bus.c_request, bus.c_evict, bus.c_we, bus.req_err, bus.evict_ack,
         |bus.c_addr, |bus.c_wdata, |bus.rdata, |bus.req_done} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got req=%b evict=%b addr=%h done=%b expected all zero",
               bus.c_request, bus.c_evict, bus.c_addr, bus.req_done);
    end
    vectors++;
    if (dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    vectors++;
    if (dbg_rr_ptr !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_rr_ptr: got %0d expected 0", dbg_rr_ptr);
    end
    bus.req = '0;
    reset   = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    addr_tbl[0] = 32'h100; addr_tbl[1] = 32'h110; addr_tbl[2] = 32'h120;
    wdata_tbl[0] = '0; wdata_tbl[1] = '0; wdata_tbl[2] = '0;
    we_tbl = 3'b000;
    load_payload();
    bus.req = 3'b001;
    tick();
    vectors++;
    if ({bus.c_request, bus.c_we, bus.c_addr} !== {1'b1, 1'b0, 32'h100}) begin
      miscompares++;
      $display("FAIL t1_latency: got req=%b we=%b addr=%h expected 1 0 00000100",
               bus.c_request, bus.c_we, bus.c_addr);
    end
    tick();
    tick();
    vectors++;
    if ({bus.c_request, bus.c_addr} !== {1'b1, 32'h100}) begin
      miscompares++;
      $display("FAIL t1_hold: got req=%b addr=%h expected 1 00000100",
               bus.c_request, bus.c_addr);
    end
    exp_q.push_back(sb_word(1'b0, 0, 32'hDEADBEEF));
    pulse_done(32'hDEADBEEF);
    bus.req = '0;
    obs_w = {bus.req_err, bus.req_done, bus.rdata};
    exp_w = exp_q.pop_front();
    vectors++;
    if (obs_w !== exp_w) begin
      miscompares++;
      $display("FAIL t1_done: got %h expected %h", obs_w, exp_w);
    end
    vectors++;
    if ({bus.c_request, dbg_rr_ptr} !== {1'b0, 2'd1}) begin
      miscompares++;
      $display("FAIL t1_rr_ptr: got req=%b rr=%0d expected req=0 rr=1",
               bus.c_request, dbg_rr_ptr);
    end
    tick();
    vectors++;
    if (bus.req_done !== 3'b000) begin
      miscompares++;
      $display("FAIL t1_done_pulse: got %b expected 000", bus.req_done);
    end
  endtask

  task automatic test_round_robin();
    int n;
    bit ok;
    int order [4];
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 0;
    do_reset();
    addr_tbl[0] = 32'h200; addr_tbl[1] = 32'h210; addr_tbl[2] = 32'h220;
    load_payload();
    bus.req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_grant(n, ok);
      vectors++;
      if (!ok || n != 1 || bus.c_addr !== addr_tbl[order[k]]) begin
        miscompares++;
        $display("FAIL t2_grant%0d: got ok=%0d gap=%0d addr=%h expected gap=1 addr=%h",
                 k, ok, n, bus.c_addr, addr_tbl[order[k]]);
      end
      exp_q.push_back(sb_word(1'b0, order[k], 32'hA000_0000 + k));
      tick();
      pulse_done(32'hA000_0000 + k);
      if (k == 3) bus.req = '0;
      obs_w = {bus.req_err, bus.req_done, bus.rdata};
      exp_w = exp_q.pop_front();
      vectors++;
      if (obs_w !== exp_w || bus.c_request !== 1'b0) begin
        miscompares++;
        $display("FAIL t2_done%0d: got %h c_req=%b expected %h c_req=0",
                 k, obs_w, bus.c_request, exp_w);
      end
    end
  endtask

  task automatic test_evict_priority();
    int n;
    bit ok;
    // rr_ptr is 1 after the previous scenario
    addr_tbl[1] = 32'h310;
    load_payload();
    bus.req        = 3'b011;
    bus.evict_req  = 1'b1;
    bus.evict_addr = 32'hE000;
    tick();
    vectors++;
    if ({bus.c_evict, bus.c_request, bus.c_addr} !== {1'b1, 1'b0, 32'hE000}) begin
      miscompares++;
      $display("FAIL t3_evict_first: got ev=%b req=%b addr=%h expected 1 0 0000e000",
               bus.c_evict, bus.c_request, bus.c_addr);
    end
    tick();
    pulse_done(32'h5555_5555);
    bus.evict_req = 1'b0;
    vectors++;
    if ({bus.evict_ack, bus.c_evict, bus.req_done, dbg_rr_ptr} !== {1'b1, 1'b0, 3'b000, 2'd1}) begin
      miscompares++;
      $display("FAIL t3_evict_ack: got ack=%b ev=%b done=%b rr=%0d expected 1 0 000 1",
               bus.evict_ack, bus.c_evict, bus.req_done, dbg_rr_ptr);
    end
    wait_grant(n, ok);
    vectors++;
    if (!ok || bus.c_request !== 1'b1 || bus.c_addr !== 32'h310) begin
      miscompares++;
      $display("FAIL t3_req_after: got ok=%0d req=%b addr=%h expected 1 00000310",
               ok, bus.c_request, bus.c_addr);
    end
    exp_q.push_back(sb_word(1'b0, 1, 32'h3333_0001));
    tick();
    pulse_done(32'h3333_0001);
    bus.req = '0;
    obs_w = {bus.req_err, bus.req_done, bus.rdata};
    exp_w = exp_q.pop_front();
    vectors++;
    if (obs_w !== exp_w) begin
      miscompares++;
      $display("FAIL t3_done: got %h expected %h", obs_w, exp_w);
    end
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    int cnt;
    do_reset();
    addr_tbl[0] = 32'h400; addr_tbl[1] = 32'h410; addr_tbl[2] = 32'h420;
    load_payload();
    bus.req = 3'b001;
    wait_grant(n, ok);
    cnt = 0;
    while (bus.c_request && cnt < 20) begin
      cnt++;
      tick();
    end
    vectors++;
    if (!ok || cnt != TIMEOUT + 1) begin
      miscompares++;
      $display("FAIL t4_req_cycles: got %0d expected %0d", cnt, TIMEOUT + 1);
    end
    exp_q.push_back(sb_word(1'b1, 0, 32'h0));
    obs_w = {bus.req_err, bus.req_done, bus.rdata};
    exp_w = exp_q.pop_front();
    vectors++;
    if (obs_w !== exp_w) begin
      miscompares++;
      $display("FAIL t4_err_done: got %h expected %h", obs_w, exp_w);
    end
    // requester 0 still asks; requester 1 must win now
    bus.req = 3'b011;
    wait_grant(n, ok);
    vectors++;
    if (!ok || bus.c_addr !== 32'h410) begin
      miscompares++;
      $display("FAIL t4_skip: got ok=%0d addr=%h expected 00000410", ok, bus.c_addr);
    end
    // c_done in the expiry cycle completes normally
    repeat (TIMEOUT) tick();
    exp_q.push_back(sb_word(1'b0, 1, 32'h4444_0001));
    pulse_done(32'h4444_0001);
    bus.req = '0;
    obs_w = {bus.req_err, bus.req_done, bus.rdata};
    exp_w = exp_q.pop_front();
    vectors++;
    if (obs_w !== exp_w) begin
      miscompares++;
      $display("FAIL t4_tie: got %h expected %h", obs_w, exp_w);
    end
    // evict watchdog
    tick();
    bus.evict_req  = 1'b1;
    bus.evict_addr = 32'hE400;
    wait_grant(n, ok);
    cnt = 0;
    while (bus.c_evict && cnt < 20) begin
      cnt++;
      tick();
    end
    bus.evict_req = 1'b0;
    vectors++;
    if (!ok || cnt != TIMEOUT + 1 || bus.evict_ack !== 1'b1 || bus.req_done !== 3'b000) begin
      miscompares++;
      $display("FAIL t4_evict_wd: got cycles=%0d ack=%b done=%b expected %0d 1 000",
               cnt, bus.evict_ack, bus.req_done, TIMEOUT + 1);
    end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    int n;
    bit ok;
    // rr_ptr is non-zero here; reset must bring it back to 0
    addr_tbl[0] = 32'h500; addr_tbl[1] = 32'h510; addr_tbl[2] = 32'h520;
    wdata_tbl[1] = 32'hCAFE_0001;
    we_tbl = 3'b010;
    load_payload();
    bus.req = 3'b010;
    wait_grant(n, ok);
    vectors++;
    if (!ok || {bus.c_we, bus.c_wdata} !== {1'b1, 32'hCAFE_0001}) begin
      miscompares++;
      $display("FAIL t5_write: got we=%b wdata=%h expected 1 cafe0001", bus.c_we, bus.c_wdata);
    end
    tick();
    reset   = 1'b1;
    bus.req = '0;
    tick();
    reset = 1'b0;
    vectors++;
    if ({bus.c_request, bus.c_we, bus.req_err, bus.evict_ack, |bus.c_addr,
         |bus.c_wdata, |bus.rdata, |bus.req_done, dbg_state, dbg_rr_ptr} !== 12'b0) begin
      miscompares++;
      $display("FAIL t5_reset: got req=%b addr=%h wdata=%h done=%b st=%0d rr=%0d expected all zero",
               bus.c_request, bus.c_addr, bus.c_wdata, bus.req_done, dbg_state, dbg_rr_ptr);
    end
    tick();
    vectors++;
    if (bus.req_done !== 3'b000) begin
      miscompares++;
      $display("FAIL t5_no_done: got %b expected 000", bus.req_done);
    end
    bus.req = 3'b100;
    wait_grant(n, ok);
    vectors++;
    if (!ok || bus.c_addr !== 32'h520) begin
      miscompares++;
      $display("FAIL t5_grant2: got ok=%0d addr=%h expected 00000520", ok, bus.c_addr);
    end
    exp_q.push_back(sb_word(1'b0, 2, 32'h5555_0002));
    tick();
    pulse_done(32'h5555_0002);
    bus.req = '0;
    obs_w = {bus.req_err, bus.req_done, bus.rdata};
    exp_w = exp_q.pop_front();
    vectors++;
    if (obs_w !== exp_w) begin
      miscompares++;
      $display("FAIL t5_done: got %h expected %h", obs_w, exp_w);
    end
  endtask

  task automatic test_drop_in_busy();
    int n;
    bit ok;
    we_tbl = 3'b000;
    load_payload();
    bus.req = 3'b010;
    wait_grant(n, ok);
    bus.req = '0;
    tick();
    tick();
    exp_q.push_back(sb_word(1'b0, 1, 32'h6666_0001));
    pulse_done(32'h6666_0001);
    obs_w = {bus.req_err, bus.req_done, bus.rdata};
    exp_w = exp_q.pop_front();
    vectors++;
    if (!ok || obs_w !== exp_w) begin
      miscompares++;
      $display("FAIL t6_drop: got ok=%0d %h expected %h", ok, obs_w, exp_w);
    end
  endtask

  task automatic test_random();
    int n;
    bit ok;
    int model_rr;
    int w;
    int j;
    int dly;
    logic [NREQ-1:0]  pattern;
    logic [WORDW-1:0] d;
    do_reset();
    model_rr = 0;
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        addr_tbl[i]  = $urandom;
        wdata_tbl[i] = $urandom;
      end
      we_tbl  = NREQ'($urandom_range(0, 7));
      pattern = NREQ'($urandom_range(1, 7));
      load_payload();
      bus.req = pattern;
      w = -1;
      for (int i = 0; i < NREQ; i++) begin
        j = (model_rr + i) % NREQ;
        if (w < 0 && pattern[j]) w = j;
      end
      wait_grant(n, ok);
      vectors++;
      if (!ok || {bus.c_addr, bus.c_wdata, bus.c_we} !== {addr_tbl[w], wdata_tbl[w], we_tbl[w]}) begin
        miscompares++;
        $display("FAIL rnd_grant%0d: got addr=%h wdata=%h we=%b expected %h %h %b",
                 it, bus.c_addr, bus.c_wdata, bus.c_we, addr_tbl[w], wdata_tbl[w], we_tbl[w]);
      end
      dly = $urandom_range(0, TIMEOUT);
      repeat (dly) tick();
      d = $urandom;
      exp_q.push_back(sb_word(1'b0, w, d));
      pulse_done(d);
      bus.req = '0;
      obs_w = {bus.req_err, bus.req_done, bus.rdata};
      exp_w = exp_q.pop_front();
      vectors++;
      if (obs_w !== exp_w) begin
        miscompares++;
        $display("FAIL rnd_done%0d: got %h expected %h", it, obs_w, exp_w);
      end
      model_rr = (w + 1) % NREQ;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_evict_priority();
    test_timeout();
    test_reset_mid_busy();
    test_drop_in_busy();
    test_random();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of run expected finish before 200000");
    $fatal(1, "simulation time limit reached");
  end

endmodule
